bin_to_bcd: RTL and testbench

Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm, one iteration per clock. It sits directly downstream of hex_to_bin and takes its unsigned binary word. It produces packed BCD digits for the recorder's seven-segment display driver (sample counts, elapsed time, level readout). It uses a start/ready/done handshake, so the display path can request a conversion only when a new value is available.

---
 rtl/bin_to_bcd.sv | 99 +++++++++
 tb/tb_bin_to_bcd.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd.sv
// bin_to_bcd: sequential double-dabble converter, one shift-and-add-3
// iteration per clock, with a start/ready/done handshake.
module bin_to_bcd #(
   parameter int BIN_W  = 16,
   parameter int DIGITS = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [BIN_W-1:0]      bin_in,
   output logic                  ready,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd_out
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int CNT_W = $clog2(BIN_W + 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t             state;
   state_t             state_nxt;
   logic [BCD_W-1:0]   bcd_work;
   logic [BCD_W-1:0]   bcd_adj;
   logic [BCD_W-1:0]   bcd_shift;
   logic [BIN_W-1:0]   bin_work;
   logic [CNT_W-1:0]   cnt;
   logic               last;

   // Add 3 to every nibble that is 5 or more; 4-bit wrap, no carry between digits.
   function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] v);
      logic [BCD_W-1:0] r;
      r = v;
      for (int i = 0; i < DIGITS; i++) begin
         if (v[4*i +: 4] >= 4'd5)
            r[4*i +: 4] = v[4*i +: 4] + 4'd3;
      end
      return r;
   endfunction

   assign bcd_adj   = add3(bcd_work);
   // Top bit of the binary word shifts into the units digit.
   assign bcd_shift = {bcd_adj[BCD_W-2:0], bin_work[BIN_W-1]};
   // The iteration in progress is the final one (counter still holds BIN_W-1).
   assign last      = (cnt == CNT_W'(BIN_W - 1));

   // Next-state decode for the IDLE -> SHIFT -> DONE sequence.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = SHIFT;
         SHIFT:   if (last)  state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State register; ready/done are registered from the next state so they carry no input path.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         ready <= 1'b1;
         done  <= 1'b0;
      end else begin
         state <= state_nxt;
         ready <= (state_nxt == IDLE);
         done  <= (state_nxt == DONE);
      end
   end

   // Working registers: load on accept, iterate in SHIFT, publish on the final iteration.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bcd_work <= '0;
         bin_work <= '0;
         cnt      <= '0;
         bcd_out  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  bcd_work <= '0;
                  bin_work <= bin_in;
                  cnt      <= '0;
               end
            end
            SHIFT: begin
               bcd_work <= bcd_shift;
               bin_work <= bin_work << 1;
               cnt      <= cnt + CNT_W'(1);
               if (last)
                  bcd_out <= bcd_shift;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_bin_to_bcd.sv
// Scoreboard bench for bin_to_bcd: driver predicts accepts and pushes expected
// results; a monitor pops and checks them whenever done is seen.
module tb_bin_to_bcd;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [15:0] bin_in;
   logic        ready;
   logic        done;
   logic [19:0] bcd_out;

   typedef struct {
      logic [19:0] val;
      int          due;
   } exp_t;

   exp_t        q[$];
   int          cyc = 0;
   int          last_accept = -1000;
   logic [19:0] last_out = '0;
   int          n_checks = 0;
   int          n_fail = 0;

   bin_to_bcd #(.BIN_W(16), .DIGITS(5)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .bin_in  (bin_in),
      .ready   (ready),
      .done    (done),
      .bcd_out (bcd_out)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Reference: decimal digits by repeated division.
   function automatic logic [19:0] ref_bcd(input int v);
      logic [19:0] r;
      int          x;
      r = '0;
      x = v;
      for (int i = 0; i < 5; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One driver cycle: check ready against the handshake model, then drive inputs.
   task automatic step(input logic s, input logic [15:0] v, output logic acc);
      logic exp_rdy;
      @(negedge clk);
      exp_rdy = ((cyc + 1 - last_accept) >= 18);
      chk("ready", 64'(ready), 64'(exp_rdy));
      start  = s;
      bin_in = v;
      acc    = s && exp_rdy;
      if (acc) begin
         q.push_back('{ref_bcd(int'(v)), cyc + 1 + 16});
         last_accept = cyc + 1;
      end
   endtask

   task automatic convert(input logic [15:0] v);
      logic acc;
      do step(1'b1, v, acc); while (!acc);
      step(1'b0, 16'h0, acc);
      repeat (20) step(1'b0, 16'(v + 16'd1), acc);
   endtask

   // Asynchronous reset applied just after a rising edge; outputs must clear at once.
   task automatic do_reset(input int cycles);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      start = 1'b0;
      q.delete();
      last_out    = '0;
      last_accept = -1000;
      #1;
      chk("rst_ready", 64'(ready), 64'd1);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_bcd", 64'(bcd_out), 64'd0);
      repeat (cycles) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // Monitor: pop on done, otherwise check bcd_out holds and no result is overdue.
   initial begin
      forever begin
         @(negedge clk);
         if (done) begin
            if (q.size() == 0) begin
               chk("spurious_done", 64'(done), 64'd0);
            end else begin
               exp_t e;
               e = q.pop_front();
               chk("bcd_out", 64'(bcd_out), 64'(e.val));
               chk("done_latency", 64'(cyc), 64'(e.due));
               last_out = e.val;
            end
         end else begin
            chk("bcd_hold", 64'(bcd_out), 64'(last_out));
            if (q.size() != 0 && cyc > q[0].due) begin
               chk("done_timeout", 64'(cyc), 64'(q[0].due));
               void'(q.pop_front());
            end
         end
      end
   end

   initial begin
      logic        acc;
      logic [15:0] vals[3];
      int          idx;
      rst_n  = 1'b1;
      start  = 1'b0;
      bin_in = '0;
      #1;
      do_reset(3);
      repeat (6) step(1'b0, 16'h0, acc);

      // Single conversions including both extremes.
      convert(16'd0);
      convert(16'd1234);
      convert(16'd9999);
      convert(16'd65535);

      // Busy isolation: a second start and churning bin_in are ignored.
      do step(1'b1, 16'd4096, acc); while (!acc);
      for (int i = 1; i <= 20; i++)
         step((i == 5), (i == 5) ? 16'd7 : 16'($urandom_range(0, 65535)), acc);
      step(1'b0, 16'h0, acc);

      // Reset in the middle of a conversion abandons it.
      do step(1'b1, 16'd54321, acc); while (!acc);
      repeat (7) step(1'b0, 16'h0, acc);
      do_reset(2);
      repeat (30) step(1'b0, 16'h0, acc);
      convert(16'd42);

      // Back-to-back with start held high.
      vals[0] = 16'd10;
      vals[1] = 16'd99;
      vals[2] = 16'd100;
      idx = 0;
      while (idx < 3) begin
         step(1'b1, vals[idx], acc);
         if (acc) idx++;
      end
      repeat (20) step(1'b0, 16'h0, acc);

      // Random back-to-back stream with boundary values mixed in.
      for (int n = 0; n < 1500; n++) begin
         logic [15:0] r;
         case ($urandom_range(0, 7))
            0:       r = 16'd0;
            1:       r = 16'hFFFF;
            2:       r = 16'd9999;
            3:       r = 16'd10000;
            default: r = 16'($urandom_range(0, 65535));
         endcase
         do step(1'b1, r, acc); while (!acc);
      end
      repeat (40) step(1'b0, 16'h0, acc);

      chk("pending_results", 64'(q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
